// File: rtl/switch_box_config_sequencer_if.sv
// switch_box_config_sequencer_if
// Purpose: valid/ready word stream that feeds header and payload words
//          from the fabric configuration port into the sequencer.
// Signals:
//   in_data   32-bit header or payload word (source -> sequencer)
//   in_valid  in_data is valid            (source -> sequencer)
//   in_ready  sequencer can take a word   (sequencer -> source)
// Modports:
//   master  the word source (drives data/valid, observes ready)
//   slave   the sequencer   (observes data/valid, drives ready)
interface switch_box_config_sequencer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/switch_box_config_sequencer.sv
// switch_box_config_sequencer
// Purpose: takes a header-plus-payload word stream and writes each payload
//          word into one switch box (or all of them, for broadcast) over a
//          shared config_data bus with per-tile one-cycle config_en pulses.
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   start        begin a load transaction (IDLE only)
//   abort        cancel the transaction in progress
//   bus          slave side of the word stream (in_data/in_valid/in_ready)
//   config_data  shared 32-bit configuration bus
//   config_en    per-tile write enable, one bit per switch box
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse alongside the final config_en
//   error        one-cycle pulse after a rejected header
// Header word: first = [15:0], count = [30:16], bcast = [31].
module switch_box_config_sequencer #(
  parameter int NUM_TILES = 16,
  parameter int IDX_W     = $clog2(NUM_TILES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  switch_box_config_sequencer_if.slave bus,
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [16:0] TILES_17 = 17'(NUM_TILES);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [14:0]          remaining, remaining_nxt;
  logic                 bcast, bcast_nxt;
  logic [31:0]          config_data_nxt;
  logic [NUM_TILES-1:0] config_en_nxt;
  logic                 done_nxt, error_nxt;

  logic                 xfer;
  logic [15:0]          hdr_first;
  logic [14:0]          hdr_count;
  logic                 hdr_bcast;
  logic [16:0]          hdr_end;
  logic                 hdr_bad;

  // Abort blocks acceptance in the same cycle so a word offered alongside
  // abort is never consumed.
  assign bus.in_ready = ((state == HDR) || (state == DATA)) && !abort;
  assign xfer         = bus.in_valid && bus.in_ready;

  // Header decode; the range sum is one bit wider than first so a large
  // first+count cannot wrap around and slip past the tile-count check.
  always_comb begin
    hdr_first = bus.in_data[15:0];
    hdr_count = bus.in_data[30:16];
    hdr_bcast = bus.in_data[31];
    hdr_end   = {1'b0, hdr_first} + {2'b00, hdr_count};
    hdr_bad   = (hdr_count == 15'd0) || (hdr_end > TILES_17) ||
                (hdr_bcast && (hdr_count != 15'd1));
  end

  // Next-state and next-output logic. config_en/done/error default to zero
  // so every pulse lasts exactly one cycle; config_data holds by default.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    remaining_nxt   = remaining;
    bcast_nxt       = bcast;
    config_data_nxt = config_data;
    config_en_nxt   = '0;
    done_nxt        = 1'b0;
    error_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = HDR;
        end
      end

      HDR: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          if (hdr_bad) begin
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt       = hdr_first[IDX_W-1:0];
            remaining_nxt = hdr_count;
            bcast_nxt     = hdr_bcast;
            state_nxt     = DATA;
          end
        end
      end

      DATA: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          config_data_nxt = bus.in_data;
          config_en_nxt   = bcast ? '1 : (NUM_TILES'(1) << idx);
          idx_nxt         = idx + IDX_W'(1);
          remaining_nxt   = remaining - 15'd1;
          if (remaining == 15'd1) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; busy is registered from the next state so
  // it always tracks the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      remaining   <= '0;
      bcast       <= 1'b0;
      config_data <= '0;
      config_en   <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      remaining   <= remaining_nxt;
      bcast       <= bcast_nxt;
      config_data <= config_data_nxt;
      config_en   <= config_en_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule
